// File: rtl/corevx_burst_mem_if.sv
// corevx_burst_mem_if: Avalon-MM burst bus between a corevx master and the burst memory slave
interface corevx_burst_mem_if #(
  parameter int ADDR_WIDTH  = 34,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   m_address;
  logic [BURST_WIDTH-1:0]  m_burstcount;
  logic                    m_read;
  logic                    m_write;
  logic [DATA_WIDTH-1:0]   m_writedata;
  logic [DATA_WIDTH/8-1:0] m_byteenable;
  logic                    m_waitrequest;
  logic [DATA_WIDTH-1:0]   m_readdata;
  logic                    m_readdatavalid;
  logic [1:0]              m_response;
  logic                    m_writeresponsevalid;
  modport master (
    output m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid, m_response, m_writeresponsevalid
  );
  modport slave (
    input  m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid, m_response, m_writeresponsevalid
  );
endinterface

// File: rtl/corevx_burst_mem.sv
// corevx_burst_mem: Avalon-MM burst memory slave with wait states, read latency, aliasing and error decode
module corevx_burst_mem #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int BURST_WIDTH = 5,
  parameter int WAIT_STATES = 0,
  parameter int READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] ALIAS_MASK = ADDR_WIDTH'(34'h0_8000_0000),
  parameter int FAULT_LO = 0,
  parameter int FAULT_HI = 0
) (
  input logic clk,
  input logic rst_n,
  corevx_burst_mem_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, RD_BURST = 2'd2, WR_BURST = 2'd3;
  localparam int WW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
  localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);
  logic [1:0] state, wacc, code, mx, resp;
  logic [WW-1:0] wcnt;
  logic [LW-1:0] lcnt;
  logic [BURST_WIDTH-1:0] rem, n;
  logic [ADDR_WIDTH-1:0] ptr, cur, a;
  logic [DEPTH_LOG2-1:0] idx;
  logic signed [31:0] widx;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata;
  logic rdv, wrv, req, waitreq, acc, acc_rd, acc_wr, lat_done, issue, wbeat;
  // one decoder serves the command in IDLE and the running beat pointer elsewhere
  always_comb begin
    cur = state == IDLE ? bus.m_address : ptr;
    a = cur & ~ALIAS_MASK;
    idx = a[DEPTH_LOG2+1:2];
    widx = 32'(idx);
    code = (|(a >> (DEPTH_LOG2 + 2))) ? 2'b11 : (widx >= FAULT_LO && widx < FAULT_HI) ? 2'b10 : 2'b00;
    mx = wacc > code ? wacc : code;
    n = bus.m_burstcount == '0 ? ONE : bus.m_burstcount;
    req = bus.m_read | bus.m_write;
    waitreq = !rst_n || !(state == WR_BURST || (state == IDLE && 32'(wcnt) == WAIT_STATES));
    acc = state == IDLE && req && !waitreq;
    acc_rd = acc && bus.m_read;
    acc_wr = acc && !bus.m_read;
    lat_done = 32'(lcnt) + 2 == READ_LATENCY;
    issue = (acc_rd && READ_LATENCY == 1) || (state == RD_WAIT && lat_done) || (state == RD_BURST && rem != '0);
    wbeat = acc_wr || (state == WR_BURST && bus.m_write && rst_n);
  end
  always_ff @(posedge clk) begin
    if (wbeat && code == 2'b00)
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (bus.m_byteenable[b]) mem[idx][8*b +: 8] <= bus.m_writedata[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      lcnt <= '0;
      rem <= '0;
      ptr <= '0;
      wacc <= 2'b00;
      rdv <= 1'b0;
      rdata <= '0;
      resp <= 2'b00;
      wrv <= 1'b0;
    end else begin
      rdv <= 1'b0;
      wrv <= 1'b0;
      resp <= 2'b00;
      if (issue) begin
        rdv <= 1'b1;
        rdata <= code == 2'b00 ? mem[idx] : '0;
        resp <= code;
      end
      case (state)
        IDLE: begin
          wcnt <= (req && !acc) ? wcnt + WW'(1) : '0;
          lcnt <= '0;
          if (acc_rd) begin
            state <= READ_LATENCY == 1 ? RD_BURST : RD_WAIT;
            rem <= READ_LATENCY == 1 ? n - ONE : n;
            ptr <= READ_LATENCY == 1 ? cur + STEP : cur;
          end else if (acc_wr && n != ONE) begin
            state <= WR_BURST;
            rem <= n - ONE;
            ptr <= cur + STEP;
            wacc <= code;
          end else if (acc_wr) begin
            wrv <= 1'b1;
            resp <= code;
          end
        end
        RD_WAIT: begin
          lcnt <= lcnt + LW'(1);
          if (lat_done) begin
            state <= RD_BURST;
            rem <= rem - ONE;
            ptr <= cur + STEP;
          end
        end
        RD_BURST: begin
          if (rem == '0) state <= IDLE;
          else begin
            rem <= rem - ONE;
            ptr <= cur + STEP;
          end
        end
        default: begin
          if (bus.m_write && rem == ONE) begin
            state <= IDLE;
            wrv <= 1'b1;
            resp <= mx;
          end else if (bus.m_write) begin
            rem <= rem - ONE;
            ptr <= cur + STEP;
            wacc <= mx;
          end
        end
      endcase
    end
  end
  assign bus.m_waitrequest = waitreq;
  assign bus.m_readdata = rdata;
  assign bus.m_readdatavalid = rdv;
  assign bus.m_response = resp;
  assign bus.m_writeresponsevalid = wrv;
endmodule

// File: tb/tb_corevx_burst_mem.sv
// tb_corevx_burst_mem: directed bench over three configurations (W0/L1 with fault region, W0/L3, W3/L1)
module tb_corevx_burst_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] sel;
  logic [33:0] addr;
  logic [4:0] bc;
  logic rd, wr;
  logic [31:0] wd;
  logic [3:0] be;
  int checks = 0;
  int failures = 0;
  logic [31:0] cap_d [32];
  logic [1:0] cap_r [32];
  int cap_t [32];
  logic cap_w [32];
  int cap_n;
  logic cap_wr;
  logic v, bad;
  logic [1:0] r;
  corevx_burst_mem_if ia ();
  corevx_burst_mem_if ib ();
  corevx_burst_mem_if ic ();
  corevx_burst_mem #(.WAIT_STATES(0), .READ_LATENCY(1), .FAULT_LO(64), .FAULT_HI(128)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  corevx_burst_mem #(.WAIT_STATES(0), .READ_LATENCY(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  corevx_burst_mem #(.WAIT_STATES(3), .READ_LATENCY(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  assign ia.m_address = addr;
  assign ia.m_burstcount = bc;
  assign ia.m_read = rd & sel[0];
  assign ia.m_write = wr & sel[0];
  assign ia.m_writedata = wd;
  assign ia.m_byteenable = be;
  assign ib.m_address = addr;
  assign ib.m_burstcount = bc;
  assign ib.m_read = rd & sel[1];
  assign ib.m_write = wr & sel[1];
  assign ib.m_writedata = wd;
  assign ib.m_byteenable = be;
  assign ic.m_address = addr;
  assign ic.m_burstcount = bc;
  assign ic.m_read = rd & sel[2];
  assign ic.m_write = wr & sel[2];
  assign ic.m_writedata = wd;
  assign ic.m_byteenable = be;
  always #5 clk = ~clk;
  function automatic logic f_wait();
    return sel[0] ? ia.m_waitrequest : sel[1] ? ib.m_waitrequest : ic.m_waitrequest;
  endfunction
  function automatic logic f_rdv();
    return sel[0] ? ia.m_readdatavalid : sel[1] ? ib.m_readdatavalid : ic.m_readdatavalid;
  endfunction
  function automatic logic [31:0] f_rd();
    return sel[0] ? ia.m_readdata : sel[1] ? ib.m_readdata : ic.m_readdata;
  endfunction
  function automatic logic [1:0] f_resp();
    return sel[0] ? ia.m_response : sel[1] ? ib.m_response : ic.m_response;
  endfunction
  function automatic logic f_wrv();
    return sel[0] ? ia.m_writeresponsevalid : sel[1] ? ib.m_writeresponsevalid : ic.m_writeresponsevalid;
  endfunction
  task automatic wait_accept(input string name);
    int t = 0;
    while (f_wait() && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (f_wait() !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept waitrequest=%b required=0 after %0d cycles", name, f_wait(), t);
    end
  endtask
  task automatic write_word(input logic [2:0] s, input logic [33:0] a, input logic [31:0] d, input logic [3:0] b,
                            output logic ov, output logic [1:0] orr);
    @(negedge clk);
    sel = s; addr = a; bc = 5'd1; wd = d; be = b; wr = 1'b1;
    wait_accept("write_word");
    @(negedge clk);
    ov = f_wrv(); orr = f_resp(); wr = 1'b0;
  endtask
  task automatic write2(input logic [2:0] s, input logic [33:0] a, input logic [31:0] d0, input logic [3:0] b0,
                        input logic [31:0] d1, input logic [3:0] b1, input logic gap,
                        output logic ov, output logic [1:0] orr, output logic obad);
    @(negedge clk);
    sel = s; addr = a; bc = 5'd2; wd = d0; be = b0; wr = 1'b1;
    wait_accept("write2");
    obad = 1'b0;
    if (gap) begin
      @(negedge clk);
      obad = f_wait() | f_wrv();
      wr = 1'b0;
    end
    @(negedge clk);
    obad = obad | f_wait() | f_wrv();
    wr = 1'b1; wd = d1; be = b1;
    @(negedge clk);
    ov = f_wrv(); orr = f_resp(); wr = 1'b0;
    @(negedge clk);
    obad = obad | f_wrv();
  endtask
  task automatic do_read(input logic [2:0] s, input logic [33:0] a, input logic [4:0] n, input logic w);
    @(negedge clk);
    sel = s; addr = a; bc = n; rd = 1'b1; wr = w; wd = 32'h0; be = 4'hF;
    wait_accept("read");
    cap_n = 0;
    cap_wr = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) begin rd = 1'b0; wr = 1'b0; end
      cap_w[k] = f_wait();
      if (f_rdv()) begin
        cap_d[cap_n] = f_rd(); cap_r[cap_n] = f_resp(); cap_t[cap_n] = k;
        cap_n++;
      end
      if (f_wrv()) cap_wr = 1'b1;
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    sel = 3'b001; addr = 34'h14; bc = 5'd1; rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (f_wait() !== 1'b1 || f_rdv() !== 1'b0 || f_resp() !== 2'b00) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d got wait=%b valid=%b resp=%b required 1 0 00", i, f_wait(), f_rdv(), f_resp());
      end
    end
    rst_n = 1'b1; rd = 1'b0;
    @(negedge clk);
    checks++;
    if (f_rdv() !== 1'b0 || f_wait() !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got valid=%b wait=%b required 0 0", f_rdv(), f_wait());
    end
  endtask
  task automatic test_single_read();
    write_word(3'b001, 34'h14, 32'hBEAFDEAD, 4'hF, v, r);
    checks++;
    if (v !== 1'b1 || r !== 2'b00) begin
      failures++;
      $display("FAIL single_write_resp got valid=%b resp=%b required 1 00", v, r);
    end
    do_read(3'b001, 34'h14, 5'd1, 1'b0);
    checks++;
    if (cap_n != 1 || cap_t[0] != 1 || cap_d[0] !== 32'hBEAFDEAD || cap_r[0] !== 2'b00) begin
      failures++;
      $display("FAIL single_read got n=%0d cyc=%0d data=%h resp=%b required 1 1 beafdead 00", cap_n, cap_t[0], cap_d[0], cap_r[0]);
    end
    checks++;
    if (cap_w[1] !== 1'b1 || cap_w[2] !== 1'b0) begin
      failures++;
      $display("FAIL single_wait got %b%b required 10", cap_w[1], cap_w[2]);
    end
    do_read(3'b001, 34'h0_8000_0014, 5'd0, 1'b0);
    checks++;
    if (cap_n != 1 || cap_d[0] !== 32'hBEAFDEAD || cap_r[0] !== 2'b00) begin
      failures++;
      $display("FAIL alias_read got n=%0d data=%h resp=%b required 1 beafdead 00", cap_n, cap_d[0], cap_r[0]);
    end
    do_read(3'b001, 34'h14, 5'd1, 1'b1);
    checks++;
    if (cap_n != 1 || cap_d[0] !== 32'hBEAFDEAD || cap_wr !== 1'b0) begin
      failures++;
      $display("FAIL read_write_both got n=%0d data=%h wrv=%b required 1 beafdead 0", cap_n, cap_d[0], cap_wr);
    end
    do_read(3'b001, 34'h14, 5'd1, 1'b0);
    checks++;
    if (cap_d[0] !== 32'hBEAFDEAD) begin
      failures++;
      $display("FAIL ignored_write got %h required beafdead", cap_d[0]);
    end
  endtask
  task automatic test_burst_read();
    for (int i = 16; i < 32; i++) write_word(3'b010, 34'(i * 4), 32'(i) * 32'h01010101, 4'hF, v, r);
    do_read(3'b010, 34'h40, 5'd16, 1'b0);
    checks++;
    if (cap_n != 16) begin
      failures++;
      $display("FAIL burst_count got %0d required 16", cap_n);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_d[i] !== 32'(i + 16) * 32'h01010101 || cap_r[i] !== 2'b00 || cap_t[i] != 3 + i) begin
        failures++;
        $display("FAIL burst_beat%0d got data=%h resp=%b cyc=%0d required %h 00 %0d", i, cap_d[i], cap_r[i], cap_t[i],
                 32'(i + 16) * 32'h01010101, 3 + i);
      end
    end
    checks++;
    if (cap_w[18] !== 1'b1 || cap_w[19] !== 1'b0) begin
      failures++;
      $display("FAIL burst_back_to_back got wait18=%b wait19=%b required 1 0", cap_w[18], cap_w[19]);
    end
  endtask
  task automatic test_byte_enable();
    write_word(3'b001, 34'h20, 32'hAAAAAAAA, 4'hF, v, r);
    write_word(3'b001, 34'h24, 32'hAAAAAAAA, 4'hF, v, r);
    write2(3'b001, 34'h20, 32'hFFCC2211, 4'b0101, 32'h12345678, 4'b1111, 1'b1, v, r, bad);
    checks++;
    if (v !== 1'b1 || r !== 2'b00 || bad !== 1'b0) begin
      failures++;
      $display("FAIL be_write_resp got valid=%b resp=%b glitch=%b required 1 00 0", v, r, bad);
    end
    do_read(3'b001, 34'h20, 5'd2, 1'b0);
    checks++;
    if (cap_n != 2 || cap_d[0] !== 32'hAACCAA11 || cap_d[1] !== 32'h12345678) begin
      failures++;
      $display("FAIL be_data got n=%0d %h %h required 2 aaccaa11 12345678", cap_n, cap_d[0], cap_d[1]);
    end
  endtask
  task automatic test_errors();
    write_word(3'b001, 34'hF8, 32'h62626262, 4'hF, v, r);
    write_word(3'b001, 34'hFC, 32'h63636363, 4'hF, v, r);
    do_read(3'b001, 34'hF8, 5'd4, 1'b0);
    checks++;
    if (cap_n != 4 || cap_r[0] !== 2'b00 || cap_r[1] !== 2'b00 || cap_r[2] !== 2'b10 || cap_r[3] !== 2'b10) begin
      failures++;
      $display("FAIL fault_resp got n=%0d %b %b %b %b required 4 00 00 10 10", cap_n, cap_r[0], cap_r[1], cap_r[2], cap_r[3]);
    end
    checks++;
    if (cap_d[0] !== 32'h62626262 || cap_d[1] !== 32'h63636363 || cap_d[2] !== 32'h0 || cap_d[3] !== 32'h0) begin
      failures++;
      $display("FAIL fault_data got %h %h %h %h required 62626262 63636363 0 0", cap_d[0], cap_d[1], cap_d[2], cap_d[3]);
    end
    write_word(3'b001, 34'h0, 32'h0000C0DE, 4'hF, v, r);
    write_word(3'b001, 34'h1_0000_0000, 32'hFFFFFFFF, 4'hF, v, r);
    checks++;
    if (v !== 1'b1 || r !== 2'b11) begin
      failures++;
      $display("FAIL decode_write_resp got valid=%b resp=%b required 1 11", v, r);
    end
    do_read(3'b001, 34'h0, 5'd1, 1'b0);
    checks++;
    if (cap_d[0] !== 32'h0000C0DE || cap_r[0] !== 2'b00) begin
      failures++;
      $display("FAIL decode_write_nomod got %h resp=%b required 0000c0de 00", cap_d[0], cap_r[0]);
    end
    do_read(3'b001, 34'h1000, 5'd1, 1'b0);
    checks++;
    if (cap_n != 1 || cap_d[0] !== 32'h0 || cap_r[0] !== 2'b11) begin
      failures++;
      $display("FAIL decode_read got n=%0d %h resp=%b required 1 0 11", cap_n, cap_d[0], cap_r[0]);
    end
    write2(3'b001, 34'h1FC, 32'hDEADBEEF, 4'hF, 32'h12800128, 4'hF, 1'b0, v, r, bad);
    checks++;
    if (v !== 1'b1 || r !== 2'b10 || bad !== 1'b0) begin
      failures++;
      $display("FAIL merge_write_resp got valid=%b resp=%b glitch=%b required 1 10 0", v, r, bad);
    end
    do_read(3'b001, 34'h1FC, 5'd2, 1'b0);
    checks++;
    if (cap_n != 2 || cap_r[0] !== 2'b10 || cap_d[0] !== 32'h0 || cap_r[1] !== 2'b00 || cap_d[1] !== 32'h12800128) begin
      failures++;
      $display("FAIL fault_hi_edge got n=%0d %b %h %b %h required 2 10 0 00 12800128", cap_n, cap_r[0], cap_d[0], cap_r[1], cap_d[1]);
    end
  endtask
  task automatic test_wait_states();
    write_word(3'b100, 34'h14, 32'hC5C5C5C5, 4'hF, v, r);
    @(negedge clk);
    sel = 3'b100; addr = 34'h14; bc = 5'd1; rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (f_wait() !== (k < 3)) begin
        failures++;
        $display("FAIL held_wait cycle %0d got %b required %b", k, f_wait(), k < 3);
      end
    end
    @(negedge clk);
    rd = 1'b0;
    checks++;
    if (f_rdv() !== 1'b1 || f_rd() !== 32'hC5C5C5C5) begin
      failures++;
      $display("FAIL wait_read got valid=%b data=%h required 1 c5c5c5c5", f_rdv(), f_rd());
    end
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (f_wait() !== (k < 3)) begin
        failures++;
        $display("FAIL drop_clears_wait cycle %0d got %b required %b", k, f_wait(), k < 3);
      end
    end
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_burst();
    logic seen;
    @(negedge clk);
    sel = 3'b100; addr = 34'h40; bc = 5'd8; rd = 1'b1;
    wait_accept("mid_reset");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rd = 1'b0;
    end
    checks++;
    if (f_rdv() !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_beat4 got valid=%b required 1", f_rdv());
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (f_rdv() !== 1'b0 || f_wait() !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_next got valid=%b wait=%b required 0 1", f_rdv(), f_wait());
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | f_rdv();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_abort got valid_seen=%b required 0", seen);
    end
    do_read(3'b100, 34'h14, 5'd1, 1'b0);
    checks++;
    if (cap_n != 1 || cap_t[0] != 1 || cap_d[0] !== 32'hC5C5C5C5) begin
      failures++;
      $display("FAIL mid_reset_idle got n=%0d cyc=%0d data=%h required 1 1 c5c5c5c5", cap_n, cap_t[0], cap_d[0]);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    sel = 3'b001; addr = '0; bc = 5'd1; rd = 1'b0; wr = 1'b0; wd = '0; be = 4'hF;
    test_reset();
    test_single_read();
    test_burst_read();
    test_byte_enable();
    test_errors();
    test_wait_states();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/corevx_burst_mem.md
# corevx_burst_mem

Parametrised, synthesizable Avalon-MM burst memory slave for the corevx memory bus (the `m_*` port set driven by `corevx_cache`). It adds multi-beat read/write bursts, configurable wait states and read latency, address aliasing, and two distinct error classes (fault region, out-of-range decode). It serves as the cache/PTW bus target in unit benches and as an on-chip RAM in small SoC builds.

## Interface
- `ADDR_WIDTH`, 34: bus address width in bits.
- `DATA_WIDTH`, 32: data width; byteenable width is `DATA_WIDTH/8`.
- `DEPTH_LOG2`, 10: log2 of memory depth in words.
- `BURST_WIDTH`, 5: width of `m_burstcount`.
- `WAIT_STATES`, 0: `m_waitrequest` high cycles before a command in IDLE is accepted.
- `READ_LATENCY`, 1: cycles from the read-accept edge to the first `m_readdatavalid`; must be ≥1.
- `ALIAS_MASK`, 34'h0_8000_0000: address bits ignored by decode.
- `FAULT_LO`, `FAULT_HI`, 0, 0: word-index range [LO, HI) answered with SLAVEERROR; empty when equal.
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `m_address` in ADDR_WIDTH: byte address; bits [1:0] are ignored.
- `m_burstcount` in BURST_WIDTH: beats; 0 is treated as 1.
- `m_read`, `m_write` in 1: command strobes.
- `m_writedata` in DATA_WIDTH; `m_byteenable` in DATA_WIDTH/8.
- `m_waitrequest` out 1: command/beat is not accepted while high.
- `m_readdata` out DATA_WIDTH; `m_readdatavalid` out 1.
- `m_response` out 2: 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR.
- `m_writeresponsevalid` out 1: one-cycle pulse carrying the write-burst response.

## Operation
- Decode per beat:
  - `a = (beat_addr & ~ALIAS_MASK)`.
  - Out of range if `a[ADDR_WIDTH-1:DEPTH_LOG2+2] != 0` → 11.
  - Otherwise, word index `a[DEPTH_LOG2+1:2]` in [FAULT_LO, FAULT_HI) → 10.
  - Otherwise 00.
- Beat address: `base + 4*i`, computed at full ADDR_WIDTH with no wrap.
- States:
  - IDLE: wait counter runs while `m_read|m_write` is high and is cleared when both are low. Accept occurs when `m_waitrequest` is low.
    - Read accepted → RD_WAIT (or RD_BURST when READ_LATENCY=1).
    - Write accepted → first beat written; → WR_BURST if count >1, else stay IDLE.
  - RD_WAIT: counts READ_LATENCY-1 cycles → RD_BURST.
  - RD_BURST: one beat per cycle with `m_readdatavalid`=1, `m_readdata`=mem or 0 on an error beat, and `m_response`=beat code. No backpressure. After the last beat → IDLE.
  - WR_BURST: `m_waitrequest` low; each cycle with `m_write` high is a beat. Cycles with `m_write` low are idle cycles within the burst. After the last beat → IDLE.
- Writes honour `m_byteenable` per byte. Error beats do not modify memory.
- Write response:
  - Merged over the burst: 11 if any beat is 11, else 10 if any beat is 10, else 00.
  - `m_writeresponsevalid` pulses the cycle after the last beat is accepted; `m_response` holds the merged code in that cycle.
- `m_read` and `m_write` both high in IDLE: treated as a read; the write is ignored.
- Command inputs are ignored outside IDLE, except `m_write` in WR_BURST.
- Memory contents are not cleared by reset.

## Timing
- `m_waitrequest` is combinational from state and counter:
  - Low in WR_BURST.
  - Low in IDLE when the wait counter == WAIT_STATES.
  - High otherwise.
  - Forced high while `rst_n` is low.
- Registered outputs reset values: `m_readdatavalid`=0, `m_readdata`=0, `m_response`=00, `m_writeresponsevalid`=0. State resets to IDLE and all counters to 0.
- Read, WAIT_STATES=0: command presented in cycle 0 and accepted at the end of cycle 0. Beat 0 appears in cycle READ_LATENCY; beat N-1 in cycle READ_LATENCY+N-1.
- WAIT_STATES=W: `m_waitrequest` is high for cycles 0..W-1 of a held request and low in cycle W, where the command is accepted.
- Back-to-back: the next command can be accepted in the first cycle after the last read beat, subject to wait states.
- Reset asserted mid-burst:
  - Next cycle: IDLE, `m_readdatavalid`=0, no `m_writeresponsevalid`.
  - Beats already written remain written.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `m_read`=1 → `m_waitrequest`=1, `m_readdatavalid`=0, `m_response`=00 throughout; no accept.
- Single read, W=0, L=1: mem[5]=32'hBEAFDEAD; read 0x14 → cycle 1 `m_readdatavalid`=1, data BEAFDEAD, response 00. Read 0x8000_0014 → same data (alias).
- Burst read, 16 beats: mem[16..31]=i*0x01010101, read at 0x40 with L=3 → valid in cycles 3..18 with data in order, response 00 each beat, then `m_waitrequest` low in cycle 19.
- Byte-enable write burst: mem[8]=mem[9]=32'hAAAAAAAA; 2-beat write at 0x20 with FFCC2211/be 0101, then 12345678/be 1111 → mem[8]=AACCAA11, mem[9]=12345678. `m_writeresponsevalid`=1 with 00 the cycle after beat 2.
- Errors, FAULT_LO=64, FAULT_HI=128:
  - 4-beat read at word 62 → responses 00,00,10,10; data 0 on beats 2–3.
  - Write to 0x1_0000_0000 → merged response 11; memory unchanged.
- Wait states and mid-burst reset, W=3:
  - Held read sees `m_waitrequest` 1,1,1,0.
  - Dropping the request after 2 cycles clears the counter.
  - `rst_n`=0 during beat 4 of an 8-beat read → next cycle `m_readdatavalid`=0 and state IDLE.
